// File: rtl/sdio_cmd_sched.sv
// sdio_cmd_sched: arbitrates software (req0) and auto-stop (req1) commands onto
// the SDIO command engine. Each command runs clear -> start -> wait, with retry
// on response timeout, a per-attempt watchdog, and one completion record.
// Ports:
//   clk_i, rstn_i         clock, async active-low reset
//   clr_stat_i            synchronous software abort/clear
//   req0_*                software request (valid/ready, op, arg, rsp_type)
//   req1_*                auto-stop request (valid/ready, arg)
//   cmd_*_o / cmd_*_i     engine interface (start/clear pulses, latched cmd, eot, status)
//   busy_o, done_*        scheduler status and completion record
module sdio_cmd_sched #(
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter logic [5:0]  STOP_OP     = 6'd12
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clr_stat_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [5:0]  req0_op_i,
  input  logic [31:0] req0_arg_i,
  input  logic [2:0]  req0_rsp_type_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_arg_i,
  output logic        cmd_start_o,
  output logic [5:0]  cmd_op_o,
  output logic [31:0] cmd_arg_o,
  output logic [2:0]  cmd_rsp_type_o,
  output logic        cmd_clr_stat_o,
  input  logic        cmd_eot_i,
  input  logic [5:0]  cmd_status_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        done_src_o,
  output logic [7:0]  done_status_o,
  output logic [1:0]  done_retries_o
);

  localparam int unsigned RETW = 2;
  localparam int unsigned WDW  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  // Retry counter is only 2 bits wide.
  if (MAX_RETRY > 3) begin : g_max_retry_chk
    $error("sdio_cmd_sched: MAX_RETRY must be <= 3");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_src;
  logic            r_retried;
  logic [RETW-1:0] r_retry;
  logic [WDW-1:0]  r_wdog;

  logic w_idle;
  logic w_acc0;
  logic w_acc1;
  logic w_cmpl;
  logic w_retry;
  logic w_wd_exp;

  // Acceptance is blocked while a software clear is pending.
  assign w_idle   = (r_state == S_IDLE) & ~clr_stat_i;
  assign w_acc1   = w_idle & req1_valid_i;
  assign w_acc0   = w_idle & req0_valid_i & ~req1_valid_i;
  // Engine drops back to idle without eot on timeout / wrong direction.
  assign w_cmpl   = cmd_eot_i | (|cmd_status_i[1:0]);
  assign w_retry  = w_cmpl & cmd_status_i[0] & ~cmd_status_i[1] &
                    (r_retry < RETW'(MAX_RETRY));
  assign w_wd_exp = ~w_cmpl & (r_wdog == '0);

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; clr_stat_i overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (clr_stat_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_acc0 | w_acc1) w_state_nxt = S_CLR;
        S_CLR:   w_state_nxt = S_ISSUE;
        S_ISSUE: w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (w_cmpl)        w_state_nxt = w_retry ? S_CLR : S_DONE;
          else if (w_wd_exp) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: pulses, readies, busy
  always_comb begin
    req0_ready_o   = w_acc0;
    req1_ready_o   = w_acc1;
    cmd_start_o    = 1'b0;
    cmd_clr_stat_o = 1'b0;
    done_o         = 1'b0;
    busy_o         = (r_state != S_IDLE);
    if (clr_stat_i) begin
      cmd_clr_stat_o = (r_state != S_IDLE);
    end else begin
      unique case (r_state)
        S_CLR:   cmd_clr_stat_o = 1'b1;
        S_ISSUE: cmd_start_o    = 1'b1;
        S_WAIT:  cmd_clr_stat_o = w_wd_exp;
        S_DONE:  done_o         = 1'b1;
        default: ;
      endcase
    end
  end

  // Command latch, retry/watchdog counters and completion record
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_op_o       <= '0;
      cmd_arg_o      <= '0;
      cmd_rsp_type_o <= '0;
      r_src          <= 1'b0;
      r_retried      <= 1'b0;
      r_retry        <= '0;
      r_wdog         <= '0;
      done_src_o     <= 1'b0;
      done_status_o  <= '0;
      done_retries_o <= '0;
    end else if (clr_stat_i) begin
      r_retried      <= 1'b0;
      r_retry        <= '0;
      r_wdog         <= '0;
      done_src_o     <= 1'b0;
      done_status_o  <= '0;
      done_retries_o <= '0;
    end else begin
      if (w_acc1) begin
        cmd_op_o       <= STOP_OP;
        cmd_arg_o      <= req1_arg_i;
        cmd_rsp_type_o <= 3'b100;
        r_src          <= 1'b1;
        r_retried      <= 1'b0;
        r_retry        <= '0;
      end else if (w_acc0) begin
        cmd_op_o       <= req0_op_i;
        cmd_arg_o      <= req0_arg_i;
        cmd_rsp_type_o <= req0_rsp_type_i;
        r_src          <= 1'b0;
        r_retried      <= 1'b0;
        r_retry        <= '0;
      end
      if (r_state == S_ISSUE) begin
        r_wdog <= WDW'(WDOG_CYCLES - 1);
      end
      if (r_state == S_WAIT) begin
        if (w_cmpl) begin
          if (w_retry) begin
            r_retry   <= r_retry + RETW'(1);
            r_retried <= 1'b1;
          end else begin
            done_src_o     <= r_src;
            done_status_o  <= {r_retried, 1'b0, cmd_status_i};
            done_retries_o <= r_retry;
          end
        end else if (w_wd_exp) begin
          done_src_o     <= r_src;
          done_status_o  <= {r_retried, 1'b1, cmd_status_i};
          done_retries_o <= r_retry;
        end else begin
          r_wdog <= r_wdog - WDW'(1);
        end
      end
    end
  end

endmodule

// File: doc/sdio_cmd_sched.md
Name: sdio_cmd_sched

Overview:
- Command scheduler in front of the SDIO command engine (CRC7 / CMD-line serializer).
- Shares the engine between two requesters:
  - software register requester (req0);
  - data-path auto-stop requester (req1, issues STOP_OP with an R1b response).
- Sequences each command as: clear engine status, start, wait for completion.
- Retries on response timeout, guards against engine hang with a watchdog, and reports one completion record per accepted request.

Parameters:
MAX_RETRY, 2, extra attempts after a response timeout (status bit0); 0 disables retry
WDOG_CYCLES, 4096, clk_i cycles allowed in WAIT per attempt before abort
STOP_OP, 6'd12, opcode issued for req1

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
clr_stat_i  in  1  synchronous software abort/clear
req0_valid_i  in  1  software command request
req0_ready_o  out  1  req0 accepted when valid&ready
req0_op_i  in  6  opcode
req0_arg_i  in  32  argument
req0_rsp_type_i  in  3  response type (000 none, 001 48crc, 010 48nocrc, 011 136, 100 48bsy)
req1_valid_i  in  1  auto-stop request
req1_ready_o  out  1  req1 accepted when valid&ready
req1_arg_i  in  32  stop argument
cmd_start_o  out  1  one-cycle start pulse to engine
cmd_op_o  out  6  latched opcode
cmd_arg_o  out  32  latched argument
cmd_rsp_type_o  out  3  latched response type
cmd_clr_stat_o  out  1  one-cycle engine clear pulse
cmd_eot_i  in  1  engine end-of-transfer pulse
cmd_status_i  in  6  engine sticky status (bit0 rsp timeout, bit1 wrong dir, bit2 busy timeout)
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle completion pulse
done_src_o  out  1  0=req0, 1=req1
done_status_o  out  8  [5:0] engine status, [6] watchdog abort, [7] retried at least once
done_retries_o  out  2  retries used

Behaviour:
- Reset values:
  - state IDLE;
  - all pulses, readies and busy_o at 0;
  - cmd_op/arg/rsp_type, done_src/status/retries at 0;
  - retry and watchdog counters at 0.
- States: IDLE, CLR, ISSUE, WAIT, DONE.
- IDLE arbitration (fixed priority):
  - req1_ready_o = req1_valid_i;
  - req0_ready_o = req0_valid_i & ~req1_valid_i;
  - both readies are 0 outside IDLE.
- On acceptance:
  - latch op/arg/rsp_type and source;
  - for req1 the latched values are op = STOP_OP, rsp_type = 3'b100;
  - clear retry count;
  - go to CLR.
- CLR: cmd_clr_stat_o=1 for exactly one cycle, then ISSUE.
- ISSUE: cmd_start_o=1 for exactly one cycle; load watchdog with WDOG_CYCLES-1; go to WAIT.
- Command outputs: cmd_op/arg/rsp_type stay stable from CLR until the next acceptance.
- Latency: start pulse is exactly 2 cycles after the acceptance cycle.
- WAIT completion: cmd_eot_i=1, or cmd_status_i[1:0]!=0. The engine returns to idle without eot on response timeout or wrong direction.
  - If completion is caused by status bit0, and bit1 is clear, and retry count < MAX_RETRY: increment retry count, set the retried flag, go to CLR.
  - Otherwise, capture cmd_status_i into done_status_o[5:0] and go to DONE.
- Watchdog: decrements every WAIT cycle.
  - On reaching 0 without completion: set done_status_o[6], pulse cmd_clr_stat_o in the same cycle, go to DONE. No retry after a watchdog abort.
  - Completion and watchdog expiry in the same cycle: completion wins.
- DONE: done_o=1 for one cycle.
  - done_src_o, done_status_o and done_retries_o are valid and held until the next DONE.
  - Return to IDLE; a new request may be accepted in the following cycle.
- clr_stat_i (any state): next state IDLE and cmd_clr_stat_o=1 that cycle, except in IDLE.
  - No done_o for the aborted request; done_* registers are cleared.
  - clr_stat_i has priority over every other event.
  - While clr_stat_i=1 in IDLE, no request is accepted.
- Asynchronous reset mid-command: immediate return to reset values; the engine is reset by the same rstn_i.
- Retry counter width is 2 bits, so MAX_RETRY must be ≤ 3; this is checked by an elaboration assertion.

Test Plan:
- req0 op=17, arg=0x1234, rsp=001; engine returns eot after 60 cycles with status 0:
  - expect clr pulse at T+1 and start at T+2 with op=17, arg=0x1234;
  - expect done_o at eot+1 with src=0, status=0x00, retries=0.
- req0 and req1 (arg=0) valid in the same cycle:
  - req1 accepted first; cmd_op_o=12, rsp_type=100;
  - req0 accepted in the cycle after req1's done;
  - done_src sequence is 1 then 0.
- Engine asserts status bit0 (no eot) on every attempt, MAX_RETRY=2:
  - expect 3 start pulses, each preceded by a clr pulse;
  - then done_status=0x81, retries=2.
- Engine asserts status bit1:
  - no retry; done_status=0x02, retries=0.
- Engine never completes, WDOG_CYCLES=16:
  - done_o 16 cycles after start+1 with done_status bit6=1;
  - cmd_clr_stat_o pulses on the expiry cycle.
- clr_stat_i asserted during WAIT:
  - one cmd_clr_stat_o pulse, state IDLE, no done_o, busy_o=0 next cycle;
  - a subsequent req0 is accepted normally.
